postnorm25: RTL

Normalise-round-pack stage of the ADDSUB2 single-precision add/subtract datapath. It sits directly downstream of the sign/magnitude post-adder and takes its sign and 25-bit magnitude plus the common (larger) exponent. It normalises the magnitude with a multi-cycle left-shift FSM, handles carry-out with round-to-nearest-even, and packs an IEEE-754 binary32 word behind a valid/ready handshake.

---
 rtl/postnorm25.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/postnorm25.sv
// postnorm25 -- normalise / round / pack stage of the ADDSUB2 binary32
// add/subtract datapath. Takes the post-adder sign, 25-bit magnitude
// (bit 24 = carry-out, bit 23 = hidden bit) and the common biased exponent.
// It normalises by shifting left one bit per cycle and handles a carry-out
// with round-to-nearest-even. The result is packed as an IEEE-754 word
// behind a valid/ready handshake. Only one operation is in flight at a time.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready is high only in IDLE)
//   in_sign, in_frac[24:0], in_exp[7:0]   post-adder result
//   out_valid / out_ready output handshake; result held until accepted
//   out_result[31:0]      {sign, exp, mant}
//   out_ovf               result rounded up to infinity
//   out_unf               result is denormal (exp field 0, mant non-zero)
module postnorm25 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [24:0] in_frac,
  input  logic [7:0]  in_exp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_ovf,
  output logic        out_unf
);

  typedef enum logic [2:0] {IDLE, EVAL, SHL, RND, DONE} state_t;

  state_t      state;
  logic        s;
  logic [24:0] f;
  logic [7:0]  e;

  // Pack a normalised-or-denormal magnitude. Returns {unf, word}.
  // An exponent of 1 without the hidden bit is a denormal, so the
  // exponent field is encoded as 0.
  function automatic logic [32:0] pack_word(input logic       sg,
                                            input logic [23:0] fr,
                                            input logic [7:0]  ex);
    logic [7:0] fld;
    logic       unf;
    fld = (ex == 8'd1 && !fr[23]) ? 8'd0 : ex;
    unf = (fld == 8'd0) && (fr[22:0] != 23'd0);
    return {unf, sg, fld, fr[22:0]};
  endfunction

  // Shift a carry-out magnitude right by one with round-to-nearest-even.
  // Only one bit is dropped, so rounding up happens only on an exact tie
  // with an odd kept LSB. A rounding carry into bit 24 needs one more
  // right shift; that shift drops a zero and is exact.
  // Returns {ovf, exp, frac}.
  function automatic logic [33:0] round_rne(input logic [24:0] fr,
                                            input logic [7:0]  ex);
    logic [24:0] t;
    logic [8:0]  ex1;
    t   = {1'b0, fr[24:1]};
    ex1 = {1'b0, ex} + 9'd1;
    if (fr[0] && t[0]) t = t + 25'd1;
    if (t[24]) begin
      t   = {1'b0, t[24:1]};
      ex1 = ex1 + 9'd1;
    end
    return {(ex1 >= 9'd255), ex1[7:0], t};
  endfunction

  logic [24:0] f_sh;
  logic [7:0]  e_dec;
  logic        shl_exit;
  logic [33:0] rnd;
  logic        rnd_ovf;
  logic [7:0]  rnd_e;
  logic [24:0] rnd_f;
  logic [32:0] pk_eval;
  logic [32:0] pk_shl;
  logic [32:0] pk_rnd;

  assign f_sh     = {f[23:0], 1'b0};
  assign e_dec    = e - 8'd1;
  // Stop once the hidden bit arrives or the exponent bottoms out at 1
  // (the result is then denormal).
  assign shl_exit = f_sh[23] || (e_dec == 8'd1);
  assign rnd      = round_rne(f, e);
  assign {rnd_ovf, rnd_e, rnd_f} = rnd;
  assign pk_eval  = pack_word(s, f[23:0], e);
  assign pk_shl   = pack_word(s, f_sh[23:0], e_dec);
  assign pk_rnd   = pack_word(s, rnd_f[23:0], rnd_e);
  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      s          <= 1'b0;
      f          <= 25'd0;
      e          <= 8'd0;
      out_valid  <= 1'b0;
      out_result <= 32'd0;
      out_ovf    <= 1'b0;
      out_unf    <= 1'b0;
    end else begin
      case (state)
        // Accept: a zero exponent has the same scale as exponent 1.
        IDLE: begin
          if (in_valid) begin
            s     <= in_sign;
            f     <= in_frac;
            e     <= (in_exp == 8'd0) ? 8'd1 : in_exp;
            state <= EVAL;
          end
        end
        // Classify the operand.
        EVAL: begin
          if (e == 8'hFF) begin
            out_result <= {s, 8'hFF, f[22:0]};
            out_ovf    <= 1'b0;
            out_unf    <= 1'b0;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else if (f == 25'd0) begin
            // Exact zero is always +0.
            out_result <= 32'd0;
            out_ovf    <= 1'b0;
            out_unf    <= 1'b0;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else if (f[24]) begin
            state <= RND;
          end else if (f[23] || e == 8'd1) begin
            out_result <= pk_eval[31:0];
            out_ovf    <= 1'b0;
            out_unf    <= pk_eval[32];
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            state <= SHL;
          end
        end
        // One-bit left normalisation per cycle.
        SHL: begin
          f <= f_sh;
          e <= e_dec;
          if (shl_exit) begin
            out_result <= pk_shl[31:0];
            out_ovf    <= 1'b0;
            out_unf    <= pk_shl[32];
            out_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        // Carry-out: right shift with rounding, saturate to infinity.
        RND: begin
          f         <= rnd_f;
          e         <= rnd_ovf ? 8'hFF : rnd_e;
          out_ovf   <= rnd_ovf;
          out_valid <= 1'b1;
          state     <= DONE;
          if (rnd_ovf) begin
            out_result <= {s, 8'hFF, 23'd0};
            out_unf    <= 1'b0;
          end else begin
            out_result <= pk_rnd[31:0];
            out_unf    <= pk_rnd[32];
          end
        end
        // Hold the result until the consumer takes it.
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
